// File: rtl/vscale_pc_redirect_ctrl.sv
// PC source sequencer: arbitrates fetch redirects and holds one stable until imem accepts it.
// Zero-cycle redirect when imem is ready; each imem_wait cycle adds one; outputs forced idle in reset.
module vscale_pc_redirect_ctrl #(
   parameter int CNT_W            = 16,
   parameter int PC_SRC_SEL_WIDTH = 3
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        imem_wait,
   input  logic                        valid_DX,
   input  logic                        stall_DX_ext,
   input  logic                        jal_DX,
   input  logic                        jalr_DX,
   input  logic                        branch_taken_DX,
   input  logic                        trap_WB,
   input  logic                        eret_WB,
   output logic [PC_SRC_SEL_WIDTH-1:0] PC_src_sel,
   output logic                        kill_IF,
   output logic                        kill_DX,
   output logic                        stall_IF,
   output logic                        stall_DX,
   output logic                        redirect_pending,
   output logic [CNT_W-1:0]            redirect_count
);

   localparam logic [PC_SRC_SEL_WIDTH-1:0] SEL_PLUS_FOUR = PC_SRC_SEL_WIDTH'(0);
   localparam logic [PC_SRC_SEL_WIDTH-1:0] SEL_BRANCH    = PC_SRC_SEL_WIDTH'(1);
   localparam logic [PC_SRC_SEL_WIDTH-1:0] SEL_JAL       = PC_SRC_SEL_WIDTH'(2);
   localparam logic [PC_SRC_SEL_WIDTH-1:0] SEL_JALR      = PC_SRC_SEL_WIDTH'(3);
   localparam logic [PC_SRC_SEL_WIDTH-1:0] SEL_REPLAY    = PC_SRC_SEL_WIDTH'(4);
   localparam logic [PC_SRC_SEL_WIDTH-1:0] SEL_HANDLER   = PC_SRC_SEL_WIDTH'(5);
   localparam logic [PC_SRC_SEL_WIDTH-1:0] SEL_EPC       = PC_SRC_SEL_WIDTH'(6);

   typedef enum logic {ST_RUN, ST_HOLD} state_t;

   state_t                        r_state;
   logic [PC_SRC_SEL_WIDTH-1:0]   r_held_sel;
   logic [CNT_W-1:0]              r_count;

   logic                          w_hold;
   logic                          w_dxq;
   logic                          w_req_vld;
   logic [PC_SRC_SEL_WIDTH-1:0]   w_req_sel;
   logic                          w_is_dx;
   logic                          w_is_wb;
   logic                          w_commit;

   assign w_hold = (r_state == ST_HOLD);
   assign w_dxq  = valid_DX & ~stall_DX_ext & (jal_DX | jalr_DX | branch_taken_DX);

   // In HOLD only WB events may displace the latched target, and only when they outrank it.
   always_comb begin
      w_req_vld = 1'b0;
      w_req_sel = SEL_PLUS_FOUR;
      if (w_hold) begin
         w_req_vld = 1'b1;
         w_req_sel = r_held_sel;
         if (trap_WB && (r_held_sel != SEL_HANDLER))
            w_req_sel = SEL_HANDLER;
         else if (eret_WB && (r_held_sel != SEL_HANDLER) && (r_held_sel != SEL_EPC))
            w_req_sel = SEL_EPC;
      end else if (trap_WB) begin
         w_req_vld = 1'b1;
         w_req_sel = SEL_HANDLER;
      end else if (eret_WB) begin
         w_req_vld = 1'b1;
         w_req_sel = SEL_EPC;
      end else if (w_dxq) begin
         w_req_vld = 1'b1;
         if (jalr_DX)     w_req_sel = SEL_JALR;
         else if (jal_DX) w_req_sel = SEL_JAL;
         else             w_req_sel = SEL_BRANCH;
      end
   end

   assign w_is_dx  = (w_req_sel == SEL_BRANCH) || (w_req_sel == SEL_JAL) || (w_req_sel == SEL_JALR);
   assign w_is_wb  = (w_req_sel == SEL_HANDLER) || (w_req_sel == SEL_EPC);
   assign w_commit = w_req_vld & ~imem_wait;

   // Outputs are gated by reset_n directly so they go idle the moment reset asserts.
   always_comb begin
      PC_src_sel       = SEL_PLUS_FOUR;
      kill_IF          = 1'b0;
      kill_DX          = 1'b0;
      stall_IF         = 1'b0;
      stall_DX         = 1'b0;
      redirect_pending = 1'b0;
      if (reset_n) begin
         redirect_pending = w_hold;
         if (w_req_vld) begin
            PC_src_sel = w_req_sel;
            if (imem_wait) begin
               stall_IF = 1'b1;
               stall_DX = w_is_dx;
            end else begin
               kill_IF  = 1'b1;
               kill_DX  = w_is_wb;
               stall_DX = w_hold & w_is_dx;
            end
         end else begin
            PC_src_sel = imem_wait ? SEL_REPLAY : SEL_PLUS_FOUR;
            stall_IF   = imem_wait;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_RUN;
         r_held_sel <= SEL_PLUS_FOUR;
         r_count    <= '0;
      end else begin
         if (w_req_vld && imem_wait) begin
            r_state    <= ST_HOLD;
            r_held_sel <= w_req_sel;
         end else if (w_commit) begin
            r_state    <= ST_RUN;
            r_held_sel <= SEL_PLUS_FOUR;
         end
         if (w_commit && (r_count != {CNT_W{1'b1}}))
            r_count <= r_count + 1'b1;
      end
   end

   assign redirect_count = r_count;

endmodule

// File: tb/tb_vscale_pc_redirect_ctrl.sv
// Bench for vscale_pc_redirect_ctrl: directed plan sequences plus random traffic against a pending-target model.
module tb_vscale_pc_redirect_ctrl;
   localparam int CW  = 5;
   localparam int MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n, imem_wait, valid_DX, stall_DX_ext, jal_DX, jalr_DX, branch_taken_DX, trap_WB, eret_WB;
   logic [2:0]    PC_src_sel;
   logic          kill_IF, kill_DX, stall_IF, stall_DX, redirect_pending;
   logic [CW-1:0] redirect_count;

   int checks   = 0;
   int failures = 0;

   // model: pending target (-1 = none) and committed count
   int m_pend = -1;
   int m_cnt  = 0;
   int s_sel, s_kif, s_kdx, s_sif, s_sdx, s_pnd, s_cnt;

   vscale_pc_redirect_ctrl #(.CNT_W(CW), .PC_SRC_SEL_WIDTH(3)) dut (
      .clk(clk), .reset_n(reset_n), .imem_wait(imem_wait), .valid_DX(valid_DX),
      .stall_DX_ext(stall_DX_ext), .jal_DX(jal_DX), .jalr_DX(jalr_DX),
      .branch_taken_DX(branch_taken_DX), .trap_WB(trap_WB), .eret_WB(eret_WB),
      .PC_src_sel(PC_src_sel), .kill_IF(kill_IF), .kill_DX(kill_DX), .stall_IF(stall_IF),
      .stall_DX(stall_DX), .redirect_pending(redirect_pending), .redirect_count(redirect_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int rank(input int s);
      case (s)
         5: return 0;
         6: return 1;
         3: return 2;
         2: return 3;
         1: return 4;
         default: return 9;
      endcase
   endfunction

   function automatic bit is_dx(input int s);
      return (s == 1) || (s == 2) || (s == 3);
   endfunction

   // Called ~1 time unit after a posedge with inputs already applied; returns 1 unit after the next posedge.
   task automatic tick();
      int r, e_sel, e_kif, e_kdx, e_sif, e_sdx, e_pnd;
      bit dxq;
      if (!reset_n) begin
         m_pend = -1;
         m_cnt  = 0;
      end
      e_sel = 0; e_kif = 0; e_kdx = 0; e_sif = 0; e_sdx = 0; e_pnd = 0;
      r = -1;
      if (reset_n) begin
         dxq = valid_DX && !stall_DX_ext && (jal_DX || jalr_DX || branch_taken_DX);
         if (m_pend >= 0) begin
            r = m_pend;
            if (trap_WB && rank(5) < rank(r)) r = 5;
            else if (eret_WB && rank(6) < rank(r)) r = 6;
         end else if (trap_WB) r = 5;
         else if (eret_WB) r = 6;
         else if (dxq) r = jalr_DX ? 3 : (jal_DX ? 2 : 1);
         e_pnd = (m_pend >= 0);
         if (r < 0) begin
            e_sel = imem_wait ? 4 : 0;
            e_sif = imem_wait;
         end else begin
            e_sel = r;
            if (imem_wait) begin
               e_sif = 1;
               e_sdx = is_dx(r);
            end else begin
               e_kif = 1;
               e_kdx = (r == 5) || (r == 6);
               e_sdx = (m_pend >= 0) && is_dx(r);
            end
         end
      end
      #3;
      s_sel = PC_src_sel; s_kif = kill_IF; s_kdx = kill_DX; s_sif = stall_IF;
      s_sdx = stall_DX; s_pnd = redirect_pending; s_cnt = redirect_count;
      check("PC_src_sel", s_sel, e_sel);
      check("kill_IF", s_kif, e_kif);
      check("kill_DX", s_kdx, e_kdx);
      check("stall_IF", s_sif, e_sif);
      check("stall_DX", s_sdx, e_sdx);
      check("redirect_pending", s_pnd, e_pnd);
      check("redirect_count", s_cnt, m_cnt);
      check("kill_stall_excl", int'(s_kif && s_sif), 0);
      if (reset_n && r >= 0) begin
         if (imem_wait) m_pend = r;
         else begin
            m_pend = -1;
            if (m_cnt < MAX) m_cnt++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit rn, input bit wt, input bit v, input bit sx, input bit jl,
                        input bit jr, input bit br, input bit tr, input bit er);
      reset_n = rn; imem_wait = wt; valid_DX = v; stall_DX_ext = sx; jal_DX = jl;
      jalr_DX = jr; branch_taken_DX = br; trap_WB = tr; eret_WB = er;
      tick();
   endtask

   task automatic idle(input bit wt);
      drive(1, wt, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int base;
      reset_n = 0; imem_wait = 0; valid_DX = 0; stall_DX_ext = 0; jal_DX = 0;
      jalr_DX = 0; branch_taken_DX = 0; trap_WB = 0; eret_WB = 0;
      @(posedge clk);
      #1;
      drive(0, 1, 1, 0, 1, 0, 0, 1, 0);
      check("rst_sel", s_sel, 0);
      check("rst_pending", s_pnd, 0);
      check("rst_count", s_cnt, 0);

      // idle with two cycles of back-pressure
      idle(0); check("idle_sel0", s_sel, 0);
      idle(1); check("idle_sel1", s_sel, 4); check("idle_sif1", s_sif, 1);
      idle(1); check("idle_sel2", s_sel, 4);
      idle(0); check("idle_sel3", s_sel, 0); check("idle_cnt", s_cnt, 0);

      // branch, imem ready
      drive(1, 0, 1, 0, 0, 0, 1, 0, 0);
      check("br_sel", s_sel, 1); check("br_kif", s_kif, 1); check("br_kdx", s_kdx, 0);
      idle(0); check("br_cnt", s_cnt, 1);

      // jalr under three cycles of back-pressure
      drive(1, 1, 1, 0, 0, 1, 0, 0, 0);
      check("jalr_sel1", s_sel, 3); check("jalr_pnd1", s_pnd, 0); check("jalr_sdx1", s_sdx, 1);
      drive(1, 1, 1, 0, 0, 1, 0, 0, 0);
      check("jalr_sel2", s_sel, 3); check("jalr_pnd2", s_pnd, 1);
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      check("jalr_sel3", s_sel, 3); check("jalr_kif3", s_kif, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("jalr_sel4", s_sel, 3); check("jalr_kif4", s_kif, 1); check("jalr_sdx4", s_sdx, 1);
      idle(0); check("jalr_cnt", s_cnt, 2);

      // trap preempts a held jal
      drive(1, 1, 1, 0, 1, 0, 0, 0, 0); check("tp_sel1", s_sel, 2);
      drive(1, 1, 0, 0, 0, 0, 0, 1, 0); check("tp_sel2", s_sel, 5); check("tp_sdx2", s_sdx, 0);
      idle(1); check("tp_sel3", s_sel, 5);
      idle(0); check("tp_sel4", s_sel, 5); check("tp_kif4", s_kif, 1); check("tp_kdx4", s_kdx, 1);
      idle(0); check("tp_cnt", s_cnt, 3);

      // priority and qualification
      drive(1, 0, 1, 0, 1, 0, 0, 1, 1); check("pri_sel", s_sel, 5);
      drive(1, 0, 1, 1, 0, 0, 1, 0, 0); check("qual_sel", s_sel, 0); check("qual_kif", s_kif, 0);

      // asynchronous reset mid-hold
      drive(1, 1, 1, 0, 1, 0, 0, 0, 0); check("hr_sel", s_sel, 2);
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      check("hr_rst_sel", s_sel, 0); check("hr_rst_sif", s_sif, 0); check("hr_rst_cnt", s_cnt, 0);
      idle(0); check("hr_run_pnd", s_pnd, 0); check("hr_run_sel", s_sel, 0);

      // saturation: drive the counter past all-ones
      for (int i = 0; i < MAX + 3; i++) drive(1, 0, 1, 0, 0, 0, 1, 0, 0);
      idle(0); check("sat_cnt", s_cnt, MAX);

      // randomized traffic
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      base = 0;
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(99) != 0), ($urandom_range(2) == 0), ($urandom_range(3) != 0),
               ($urandom_range(4) == 0), ($urandom_range(5) == 0), ($urandom_range(6) == 0),
               ($urandom_range(4) == 0), ($urandom_range(15) == 0), ($urandom_range(11) == 0));
         if (s_cnt == MAX) base++;
      end
      check("rand_saw_sat", int'(base > 0), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
